idst4x4_2d: RTL and testbench



---
 rtl/idst4x4_2d_pkg.sv | 39 +++
 rtl/idst4x4_2d_core.sv | 50 +++++
 rtl/idst4x4_2d.sv | 133 +++++++++++++
 tb/tb_idst4x4_2d.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idst4x4_2d_pkg.sv
// Shared constants, types and rounding helper for the 4x4 inverse DST.
// Used by the 2-D engine and its 4-point core.
package idst4x4_2d_pkg;

  localparam int COEF_W     = 16;
  localparam int SUM_W      = 26;
  localparam int SHIFT1_DEF = 7;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  localparam sum_t K29 = 26'sd29;
  localparam sum_t K55 = 26'sd55;
  localparam sum_t K74 = 26'sd74;
  localparam sum_t K84 = 26'sd84;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_COL  = 2'd1;
  localparam logic [1:0] ST_ROW  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam sum_t SAT_MAX = sum_t'((1 << (COEF_W-1)) - 1);
  localparam sum_t SAT_MIN = -SAT_MAX - sum_t'(1);

  // Round half up, floor-shift, then clip to the coefficient range.
  function automatic coef_t round_sat(input sum_t y,
                                      input int unsigned sh);
    sum_t rnd;
    sum_t r;
    rnd = sum_t'(1) <<< (sh - 1);
    r   = (y + rnd) >>> sh;
    if (r > SAT_MAX)
      r = SAT_MAX;
    else if (r < SAT_MIN)
      r = SAT_MIN;
    return r[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/idst4x4_2d_core.sv
// 4-point inverse DST butterfly with a two-register pipeline.
// Operand in cycle t yields its 26-bit sums in cycle t+2.
module idst4_core
  import idst4x4_2d_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  coef_t c_i [4],
  output sum_t  y_o [4]
);

  sum_t e   [4];
  sum_t p_d [8];
  sum_t p_q [8];
  sum_t y_q [4];

  always_comb begin
    for (int k = 0; k < 4; k++)
      e[k] = sum_t'(c_i[k]);
  end

  // Stage 1 splits each output into two partial sums.
  always_comb begin
    p_d[0] = K29*e[0] + K74*e[1];
    p_d[1] = K84*e[2] + K55*e[3];
    p_d[2] = K55*e[0] + K74*e[1];
    p_d[3] = -(K29*e[2]) - K84*e[3];
    p_d[4] = K74*e[0];
    p_d[5] = K74*e[3] - K74*e[2];
    p_d[6] = K84*e[0] - K74*e[1];
    p_d[7] = K55*e[2] - K29*e[3];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++)
        p_q[i] <= '0;
      for (int i = 0; i < 4; i++)
        y_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        p_q[i] <= p_d[i];
      for (int i = 0; i < 4; i++)
        y_q[i] <= p_q[2*i] + p_q[2*i+1];
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/idst4x4_2d.sv
// 2-D 4x4 inverse DST: load rows, column pass, row pass, emit rows.
// One shared 1-D core serves both passes.
module idst4x4_2d #(
  parameter int BIT_DEPTH = 8,
  parameter int SHIFT1    = idst4x4_2d_pkg::SHIFT1_DEF,
  parameter int SHIFT2    = 20 - BIT_DEPTH,
  parameter int COEF_W    = idst4x4_2d_pkg::COEF_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [4*COEF_W-1:0] i_row,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [4*COEF_W-1:0] o_row,
  output logic [1:0]          o_row_idx,
  output logic                o_busy
);
  import idst4x4_2d_pkg::*;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  coef_t cbuf_q [4][4];
  coef_t ebuf_q [4][4];
  coef_t rbuf_q [4][4];

  coef_t core_c [4];
  sum_t  core_y [4];

  logic [1:0] ridx;
  logic [1:0] widx;
  logic       wr_en;
  logic       fire_in;
  logic       fire_out;

  assign ridx     = cnt_q[1:0];
  assign widx     = cnt_q[1:0] - 2'd2;
  assign wr_en    = (cnt_q >= 3'd2);
  assign i_ready  = (state_q == ST_LOAD);
  assign o_valid  = (state_q == ST_OUT);
  assign o_busy   = !i_ready;
  assign fire_in  = i_valid & i_ready;
  assign fire_out = o_valid & o_ready;
  assign o_row_idx = o_valid ? cnt_q[1:0] : 2'd0;

  always_comb begin
    o_row = '0;
    if (o_valid)
      for (int j = 0; j < 4; j++)
        o_row[j*COEF_W +: COEF_W] = rbuf_q[cnt_q[1:0]][j];
  end

  // COL and ROW each last 6 cycles: 4 issues plus 2 pipeline drains.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LOAD: if (fire_in) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          state_d = ST_COL;
          cnt_d   = '0;
        end
      end
      ST_COL: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = ST_ROW;
          cnt_d   = '0;
        end
      end
      ST_ROW: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = ST_OUT;
          cnt_d   = '0;
        end
      end
      ST_OUT: if (fire_out) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++)
      core_c[k] = '0;
    if (cnt_q < 3'd4) begin
      if (state_q == ST_COL)
        for (int k = 0; k < 4; k++)
          core_c[k] = cbuf_q[k][ridx];
      else if (state_q == ST_ROW)
        for (int k = 0; k < 4; k++)
          core_c[k] = ebuf_q[ridx][k];
    end
  end

  idst4_core u_core (
    .clk (clk),
    .rst (rst),
    .c_i (core_c),
    .y_o (core_y)
  );

  always_ff @(posedge clk) begin
    if (fire_in)
      for (int j = 0; j < 4; j++)
        cbuf_q[cnt_q[1:0]][j] <= i_row[j*COEF_W +: COEF_W];
    if (state_q == ST_COL && wr_en)
      for (int k = 0; k < 4; k++)
        ebuf_q[k][widx] <= round_sat(core_y[k], SHIFT1);
    if (state_q == ST_ROW && wr_en)
      for (int k = 0; k < 4; k++)
        rbuf_q[widx][k] <= round_sat(core_y[k], SHIFT2);
  end

endmodule

// File: tb/tb_idst4x4_2d.sv
// Self-checking bench for idst4x4_2d: directed table, random blocks,
// backpressure, streaming and mid-block reset.
module tb_idst4x4_2d;

  typedef logic signed [15:0] s16_t;
  typedef s16_t mat_t [4][4];

  typedef struct packed {
    logic [15:0]           dc;
    logic [3:0][15:0]      e0;
    logic [3:0][3:0][15:0] r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [63:0] i_row;
  logic        o_valid;
  logic        o_ready;
  logic [63:0] o_row;
  logic [1:0]  o_row_idx;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  int M [4][4] = '{'{29, 55, 74, 84},
                   '{74, 74, 0, -74},
                   '{84, -29, -74, 55},
                   '{55, -84, 74, -29}};

  idst4x4_2d dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_row     (i_row),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_row     (o_row),
    .o_row_idx (o_row_idx),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst && i_valid && i_ready)
      acc_cnt++;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout got=none exp=event", nm);
  endtask

  function automatic logic [63:0] z16(input logic [15:0] v);
    return {48'd0, v};
  endfunction

  function automatic logic [63:0] pack_row(input mat_t m, input int r);
    return {m[r][3], m[r][2], m[r][1], m[r][0]};
  endfunction

  function automatic longint rs(input longint y, input int sh);
    longint v;
    v = (y + (longint'(1) << (sh - 1))) >>> sh;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // Reference: E = column pass with matrix M^T, R = row pass.
  function automatic void model(input mat_t c, output mat_t r);
    mat_t   e;
    longint acc;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int m = 0; m < 4; m++)
          acc += longint'(M[m][k]) * longint'(c[m][j]);
        e[k][j] = s16_t'(rs(acc, 7));
      end
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 4; n++) begin
        acc = 0;
        for (int m = 0; m < 4; m++)
          acc += longint'(M[m][n]) * longint'(e[i][m]);
        r[i][n] = s16_t'(rs(acc, 12));
      end
  endfunction

  function automatic void rand_mat(output mat_t c, input bit full);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (full)
          c[i][j] = s16_t'($urandom_range(0, 65535));
        else
          c[i][j] = s16_t'(int'($urandom_range(0, 2047)) - 1024);
  endfunction

  task automatic drive_rows(input mat_t c);
    int g;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_row   = pack_row(c, r);
      g = 0;
      while (!i_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) timeout("load");
      @(posedge clk);
    end
  endtask

  task automatic send_block(input mat_t c, output int lat);
    drive_rows(c);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        i_valid = 1'b0;
        check("busy_after_load", z16({15'd0, o_busy}), 64'd1);
        check("iready_after_load", z16({15'd0, i_ready}), 64'd0);
      end
    end while (!o_valid && lat < 50);
  endtask

  task automatic recv_block(input mat_t exp, input int bp_row,
                            input int bp_n, input string tag);
    int g;
    for (int i = 0; i < 4; i++) begin
      g = 0;
      while (!o_valid && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) timeout({tag, "_ovalid"});
      check($sformatf("%s_row%0d", tag, i), o_row, pack_row(exp, i));
      check($sformatf("%s_idx%0d", tag, i), z16({14'd0, o_row_idx}),
            z16(16'(i)));
      if (i == bp_row) begin
        o_ready = 1'b0;
        for (int b = 0; b < bp_n; b++) begin
          @(negedge clk);
          check($sformatf("%s_bp_row%0d", tag, b), o_row,
                pack_row(exp, i));
          check($sformatf("%s_bp_idx%0d", tag, b),
                z16({14'd0, o_row_idx}), z16(16'(i)));
          check($sformatf("%s_bp_irdy%0d", tag, b),
                z16({15'd0, i_ready}), 64'd0);
        end
      end
      o_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_irdy_after"}, z16({15'd0, i_ready}), 64'd1);
  endtask

  vec_t vec [2];
  mat_t c, exp_r, blk [3], bexp [3];
  int   lat;
  int   base;

  initial begin
    vec[0].dc = 16'd4096;
    vec[0].e0[0] = 16'd928;  vec[0].e0[1] = 16'd1760;
    vec[0].e0[2] = 16'd2368; vec[0].e0[3] = 16'd2688;
    vec[0].r[0] = {16'd19, 16'd17, 16'd12, 16'd7};
    vec[0].r[1] = {16'd36, 16'd32, 16'd24, 16'd12};
    vec[0].r[2] = {16'd49, 16'd43, 16'd32, 16'd17};
    vec[0].r[3] = {16'd55, 16'd49, 16'd36, 16'd19};
    vec[1].dc = -16'sd4096;
    vec[1].e0[0] = -16'sd928;  vec[1].e0[1] = -16'sd1760;
    vec[1].e0[2] = -16'sd2368; vec[1].e0[3] = -16'sd2688;
    vec[1].r[0] = {-16'sd19, -16'sd17, -16'sd12, -16'sd7};
    vec[1].r[1] = {-16'sd36, -16'sd32, -16'sd24, -16'sd12};
    vec[1].r[2] = {-16'sd49, -16'sd43, -16'sd32, -16'sd17};
    vec[1].r[3] = {-16'sd55, -16'sd49, -16'sd36, -16'sd19};

    rst = 1'b0;
    i_valid = 1'b0;
    i_row = '0;
    o_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_iready", z16({15'd0, i_ready}), 64'd1);
    check("rst_ovalid", z16({15'd0, o_valid}), 64'd0);
    check("rst_orow", o_row, 64'd0);
    check("rst_idx", z16({14'd0, o_row_idx}), 64'd0);
    check("rst_busy", z16({15'd0, o_busy}), 64'd0);
    rst = 1'b1;

    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          c[i][j] = '0;
          exp_r[i][j] = s16_t'(vec[t].r[i][j]);
        end
      c[0][0] = s16_t'(vec[t].dc);
      send_block(c, lat);
      check($sformatf("dc%0d_latency", t), z16(16'(lat)), 64'd13);
      for (int k = 0; k < 4; k++)
        check($sformatf("dc%0d_e%0d", t, k),
              z16(dut.ebuf_q[k][0]), z16(vec[t].e0[k]));
      recv_block(exp_r, -1, 0, $sformatf("dc%0d", t));
    end

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        c[i][j] = 16'sd32767;
    model(c, exp_r);
    send_block(c, lat);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("sat_e0_%0d", j), z16(dut.ebuf_q[0][j]),
            z16(16'd32767));
      check($sformatf("sat_e2_%0d", j), z16(dut.ebuf_q[2][j]),
            z16(16'd18943));
    end
    recv_block(exp_r, -1, 0, "sat");

    rand_mat(c, 1'b0);
    model(c, exp_r);
    send_block(c, lat);
    recv_block(exp_r, 1, 5, "bp");

    for (int n = 0; n < 3; n++) begin
      rand_mat(c, n[0]);
      model(c, exp_r);
      send_block(c, lat);
      check($sformatf("rnd%0d_latency", n), z16(16'(lat)), 64'd13);
      recv_block(exp_r, -1, 0, $sformatf("rnd%0d", n));
    end

    for (int b = 0; b < 3; b++) begin
      rand_mat(blk[b], b != 1);
      model(blk[b], bexp[b]);
    end
    base = acc_cnt;
    fork
      begin
        for (int b = 0; b < 3; b++)
          drive_rows(blk[b]);
        @(negedge clk);
        i_valid = 1'b0;
      end
      begin
        for (int b = 0; b < 3; b++) begin
          recv_block(bexp[b], -1, 0, $sformatf("str%0d", b));
          check($sformatf("str%0d_beats", b), z16(16'(acc_cnt - base)),
                z16(16'(4 * (b + 1))));
        end
      end
    join

    rand_mat(c, 1'b1);
    drive_rows(c);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_iready", z16({15'd0, i_ready}), 64'd1);
    check("mid_ovalid", z16({15'd0, o_valid}), 64'd0);
    check("mid_orow", o_row, 64'd0);
    check("mid_idx", z16({14'd0, o_row_idx}), 64'd0);
    check("mid_busy", z16({15'd0, o_busy}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("stale%0d", k), z16({15'd0, o_valid}), 64'd0);
    end
    rand_mat(c, 1'b0);
    model(c, exp_r);
    send_block(c, lat);
    check("post_rst_latency", z16(16'(lat)), 64'd13);
    recv_block(exp_r, -1, 0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
